// File: rtl/key_cond_pkg.sv
// Shared types and defaults for the multiplier key conditioner.
// Debouncer state encoding plus the default debounce length (1 ms at 50 MHz).
package key_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int KEY_DEBOUNCE_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/key_debounce.sv
// One active-low pushbutton: 2-flop synchronizer, debounce counter and FSM.
// Emits a single-cycle pulse on an accepted press and a debounced held level.
module key_debounce
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key_n_raw,
  output logic pulse,
  output logic held
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);

  logic       sync1_r;
  logic       sync2_r;
  key_state_t state_r;
  logic [CW-1:0] cnt_r;
  logic       pulse_r;
  logic       held_r;

  // Synchronizer; flops reset to the released level so reset never looks like a press.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n_raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce FSM; pulse and held are registered alongside the state.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r <= RELEASED;
      cnt_r   <= CNT_ZERO;
      pulse_r <= 1'b0;
      held_r  <= 1'b0;
    end else begin
      pulse_r <= 1'b0;
      case (state_r)
        RELEASED: begin
          if (!sync2_r) begin
            state_r <= PRESS_WAIT;
            cnt_r   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (sync2_r) begin
            state_r <= RELEASED;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == CNT_MAX) begin
            state_r <= PRESSED;
            cnt_r   <= CNT_ZERO;
            pulse_r <= 1'b1;
            held_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        PRESSED: begin
          if (sync2_r) begin
            state_r <= RELEASE_WAIT;
            cnt_r   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (!sync2_r) begin
            state_r <= PRESSED;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == CNT_MAX) begin
            state_r <= RELEASED;
            cnt_r   <= CNT_ZERO;
            held_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= RELEASED;
          cnt_r   <= CNT_ZERO;
          pulse_r <= 1'b0;
          held_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pulse = pulse_r;
  assign held  = held_r;

endmodule

// File: rtl/multiplier_key_conditioner.sv
// Input stage for the shift-add multiplier: debounced Run / ClearA_LoadB
// command pulses and a synchronized switch operand.
module multiplier_key_conditioner
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEFAULT,
  parameter int SW_WIDTH        = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Run_n_raw,
  input  logic                ClearA_LoadB_n_raw,
  input  logic [SW_WIDTH-1:0] SW_raw,
  output logic                Run_pulse,
  output logic                ClearA_LoadB_pulse,
  output logic                Run_held,
  output logic                ClearA_LoadB_held,
  output logic [SW_WIDTH-1:0] S
);

  logic [SW_WIDTH-1:0] sw_sync1_r;
  logic [SW_WIDTH-1:0] sw_sync2_r;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_key (
    .Clk      (Clk),
    .Reset    (Reset),
    .key_n_raw(Run_n_raw),
    .pulse    (Run_pulse),
    .held     (Run_held)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_load_key (
    .Clk      (Clk),
    .Reset    (Reset),
    .key_n_raw(ClearA_LoadB_n_raw),
    .pulse    (ClearA_LoadB_pulse),
    .held     (ClearA_LoadB_held)
  );

  // Switches are only synchronized; the multiplier samples S on a command pulse.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sw_sync1_r <= {SW_WIDTH{1'b0}};
      sw_sync2_r <= {SW_WIDTH{1'b0}};
    end else begin
      sw_sync1_r <= SW_raw;
      sw_sync2_r <= sw_sync1_r;
    end
  end

  assign S = sw_sync2_r;

endmodule

// File: doc/multiplier_key_conditioner.md
# multiplier_key_conditioner

Front-end input stage for the 8-bit shift-add multiplier. It takes the raw, asynchronous, active-low DE2 pushbuttons and slide switches, synchronizes them to `Clk`, and debounces the buttons. It delivers single-cycle command pulses (`Run`, `ClearA_LoadB`) and a synchronized switch operand to the multiplier's control unit and register file. The multiplier therefore never sees metastable, bouncing or multi-cycle commands.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a key change (1 ms at 50 MHz). Minimum 2.
- `SW_WIDTH`, default 8: switch bus width.

Ports:
- `Clk`  in  1  system clock; all state updates on its rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `Run_n_raw`  in  1  raw Run pushbutton, active-low, asynchronous.
- `ClearA_LoadB_n_raw`  in  1  raw ClearA/LoadB pushbutton, active-low, asynchronous.
- `SW_raw`  in  SW_WIDTH  raw slide switches, asynchronous.
- `Run_pulse`  out  1  one-cycle high pulse on accepted Run press.
- `ClearA_LoadB_pulse`  out  1  one-cycle high pulse on accepted ClearA/LoadB press.
- `Run_held`  out  1  debounced level, 1 while Run is held.
- `ClearA_LoadB_held`  out  1  debounced level, 1 while ClearA/LoadB is held.
- `S`  out  SW_WIDTH  synchronized switch value (multiplicand/multiplier operand).

## Operation
- Each raw input passes through a 2-flop synchronizer. Key synchronizer flops reset to 1 (released). Switch flops reset to 0.
- Each key has an independent debouncer with the following state:
  - `stable` (debounced pressed flag).
  - A counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`.
  - A 4-state FSM: `RELEASED`, `PRESS_WAIT`, `PRESSED`, `RELEASE_WAIT`.
- FSM transitions, where `k` is the synchronized key, active-low:
  - `RELEASED`: if `k==0`, go to `PRESS_WAIT` with `cnt=1`. Otherwise stay.
  - `PRESS_WAIT`:
    - if `k==1`, go to `RELEASED` with `cnt=0` (glitch rejected).
    - else if `cnt==DEBOUNCE_CYCLES-1`, go to `PRESSED`, assert the pulse for exactly the next cycle, and set `cnt=0`.
    - else increment `cnt`.
  - `PRESSED`: if `k==1`, go to `RELEASE_WAIT` with `cnt=1`.
  - `RELEASE_WAIT`:
    - if `k==0`, go to `PRESSED` with `cnt=0`.
    - else if `cnt==DEBOUNCE_CYCLES-1`, go to `RELEASED` with no pulse.
    - else increment `cnt`.
- `*_held` is 1 in `PRESSED` and `RELEASE_WAIT`, and 0 otherwise.
- A pulse is issued only on the `PRESS_WAIT`→`PRESSED` transition. A key held indefinitely produces exactly one pulse.
- The two keys are fully independent. Both pulses may assert in the same cycle.
- Switches are synchronized only, not debounced. The multiplier samples `S` only on `ClearA_LoadB_pulse`/`Run_pulse`.

## Timing
- Reset (`Reset==0` at a rising edge) values:
  - FSMs in `RELEASED`, counters 0.
  - `Run_pulse`, `ClearA_LoadB_pulse`, `Run_held`, `ClearA_LoadB_held` = 0.
  - `S` = 0.
  - Reset has priority over all other activity.
- Press latency: raw key first sampled low at edge E and held low. The pulse and `held` go high in the cycle after edge E+1+DEBOUNCE_CYCLES. The pulse is high for exactly one cycle.
- Release latency: same count. `held` drops after DEBOUNCE_CYCLES+2 edges of stable release.
- Switch latency: `S` reflects `SW_raw` 2 edges after sampling.
- Reset mid-debounce: all progress is discarded. A key still held after reset release restarts from `RELEASED` and yields one pulse after the full press latency.
- A bounce shorter than DEBOUNCE_CYCLES synchronized cycles causes no state change and no pulse.

## Structure
- Package `key_cond_pkg` holds:
  - `typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} key_state_t`.
  - `localparam` default `DEBOUNCE_CYCLES`.
- Sub-module `key_debounce` contains one key's synchronizer, counter and FSM. It has ports `Clk`, `Reset`, `key_n_raw`, `pulse`, `held`, and a `DEBOUNCE_CYCLES` parameter.
- The top instantiates `key_debounce` twice. The switch synchronizer is inline.

## Test plan
All directed scenarios run with `DEBOUNCE_CYCLES=4`.
- Clean press: `Run_n_raw` 1→0 sampled at edge 0 and held → `Run_pulse` high only in the cycle after edge 5. `Run_held`=1 from then on.
- Bounce: `ClearA_LoadB_n_raw` low 2 cycles, high 1 cycle, low 1 cycle, high 1 cycle, then low held → exactly one `ClearA_LoadB_pulse`, occurring 6 edges after the final fall. No earlier pulse.
- Long hold then release: Run held 100 cycles → exactly one pulse. After release, `Run_held` goes to 0 6 edges after the rise, with no pulse on release.
- Simultaneous keys: both raw keys fall at the same edge → both pulses assert in the same single cycle.
- Reset mid-debounce: Run falls, `Reset`=0 at edge 3, `Reset`=1 at edge 4, Run still held → no pulse before edge 4+6. One pulse after it. All outputs 0 during reset.
- Switches: `SW_raw`=8'hC5 then 8'h07 → `S` shows 8'hC5, then 8'h07, each 2 edges after the change. `S`=8'h00 after reset.
